// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter for a single shared memory port.
// Round-robin on contention; one outstanding transaction; accept -> request -> response.
module mem_arbiter #(
    parameter int XLEN  = 32,
    parameter int MASKW = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ifu_valid_i,
    input  logic [XLEN-1:0]  ifu_addr_i,
    output logic             ifu_ready_o,
    output logic             ifu_rvalid_o,
    output logic [XLEN-1:0]  ifu_rdata_o,
    input  logic             lsu_valid_i,
    input  logic             lsu_wen_i,
    input  logic [XLEN-1:0]  lsu_addr_i,
    input  logic [MASKW-1:0] lsu_mask_i,
    input  logic [XLEN-1:0]  lsu_wdata_i,
    output logic             lsu_ready_o,
    output logic             lsu_rvalid_o,
    output logic [XLEN-1:0]  lsu_rdata_o,
    output logic             mem_valid_o,
    output logic             mem_wen_o,
    output logic [XLEN-1:0]  mem_addr_o,
    output logic [MASKW-1:0] mem_mask_o,
    output logic [XLEN-1:0]  mem_wdata_o,
    input  logic             mem_ready_i,
    input  logic             mem_rvalid_i,
    input  logic [XLEN-1:0]  mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    owner_e           last_owner_q, last_owner_d;
    logic             wen_q, wen_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [MASKW-1:0] mask_q, mask_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic             rst_dly_q, rst_dly_d;
    logic             grant_ifu, grant_lsu;
    logic             out_en;
    logic             resp_fire;

    always_ff @(posedge clk_i) begin
        rst_dly_q <= rst_dly_d;
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IFU;
            last_owner_q <= OWN_IFU;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            mask_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            mask_q       <= mask_d;
            wdata_q      <= wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        mask_d       = mask_q;
        wdata_d      = wdata_q;
        rst_dly_d    = rst_i;
        grant_ifu    = 1'b0;
        grant_lsu    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // No grant in the cycle after reset: outputs stay quiet for that cycle.
                if (!rst_dly_q) begin
                    if (ifu_valid_i && (!lsu_valid_i || last_owner_q == OWN_LSU)) begin
                        grant_ifu = 1'b1;
                    end else if (lsu_valid_i) begin
                        grant_lsu = 1'b1;
                    end
                end
                if (grant_ifu) begin
                    state_d      = REQ;
                    owner_d      = OWN_IFU;
                    last_owner_d = OWN_IFU;
                    wen_d        = 1'b0;
                    addr_d       = ifu_addr_i;
                    mask_d       = '1;
                    wdata_d      = '0;
                end else if (grant_lsu) begin
                    state_d      = REQ;
                    owner_d      = OWN_LSU;
                    last_owner_d = OWN_LSU;
                    wen_d        = lsu_wen_i;
                    addr_d       = lsu_addr_i;
                    mask_d       = lsu_mask_i;
                    wdata_d      = lsu_wdata_i;
                end
            end
            REQ: begin
                if (mem_ready_i) state_d = RESP;
            end
            RESP: begin
                if (mem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_en       = !(rst_i || rst_dly_q);
        resp_fire    = (state_q == RESP) && mem_rvalid_i;
        ifu_ready_o  = 1'b0;
        lsu_ready_o  = 1'b0;
        ifu_rvalid_o = 1'b0;
        lsu_rvalid_o = 1'b0;
        ifu_rdata_o  = '0;
        lsu_rdata_o  = '0;
        mem_valid_o  = 1'b0;
        mem_wen_o    = 1'b0;
        mem_addr_o   = '0;
        mem_mask_o   = '0;
        mem_wdata_o  = '0;
        if (out_en) begin
            ifu_ready_o  = grant_ifu;
            lsu_ready_o  = grant_lsu;
            mem_valid_o  = (state_q == REQ);
            mem_wen_o    = wen_q;
            mem_addr_o   = addr_q;
            mem_mask_o   = mask_q;
            mem_wdata_o  = wdata_q;
            ifu_rvalid_o = resp_fire && (owner_q == OWN_IFU);
            lsu_rvalid_o = resp_fire && (owner_q == OWN_LSU);
            if (ifu_rvalid_o && !wen_q) ifu_rdata_o = mem_rdata_i;
            if (lsu_rvalid_o && !wen_q) lsu_rdata_o = mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter: one vector per clock cycle,
// plus a hand-written reset-during-request sequence with a bounded grant wait.
module tb_mem_arbiter;

    localparam int XLEN  = 32;
    localparam int MASKW = 8;
    localparam bit O = 1'b0;
    localparam bit I = 1'b1;
    localparam logic [31:0] Z = 32'h0;

    typedef struct {
        bit          rst;
        bit          iv;
        logic [31:0] iaddr;
        bit          lv;
        bit          lwen;
        logic [31:0] laddr;
        logic [7:0]  lmask;
        logic [31:0] lwdata;
        bit          mrdy;
        bit          mrv;
        logic [31:0] mrdata;
        logic [4:0]  ctrl;   // {ifu_ready, ifu_rvalid, lsu_ready, lsu_rvalid, mem_valid}
        logic [31:0] irdata;
        logic [31:0] lrdata;
        bit          mwen;
        logic [31:0] maddr;
        logic [7:0]  mmask;
        logic [31:0] mwdata;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_i = 1'b0;
    logic             ifu_valid_i = 1'b0;
    logic [XLEN-1:0]  ifu_addr_i = '0;
    logic             ifu_ready_o, ifu_rvalid_o;
    logic [XLEN-1:0]  ifu_rdata_o;
    logic             lsu_valid_i = 1'b0, lsu_wen_i = 1'b0;
    logic [XLEN-1:0]  lsu_addr_i = '0, lsu_wdata_i = '0;
    logic [MASKW-1:0] lsu_mask_i = '0;
    logic             lsu_ready_o, lsu_rvalid_o;
    logic [XLEN-1:0]  lsu_rdata_o;
    logic             mem_valid_o, mem_wen_o;
    logic [XLEN-1:0]  mem_addr_o, mem_wdata_o;
    logic [MASKW-1:0] mem_mask_o;
    logic             mem_ready_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [XLEN-1:0]  mem_rdata_i = '0;

    int checks = 0;
    int passed = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(XLEN), .MASKW(MASKW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ifu_valid_i(ifu_valid_i), .ifu_addr_i(ifu_addr_i), .ifu_ready_o(ifu_ready_o),
        .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o),
        .lsu_valid_i(lsu_valid_i), .lsu_wen_i(lsu_wen_i), .lsu_addr_i(lsu_addr_i),
        .lsu_mask_i(lsu_mask_i), .lsu_wdata_i(lsu_wdata_i), .lsu_ready_o(lsu_ready_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
        .mem_mask_o(mem_mask_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL v%0d %s: got %h expected %h", idx, name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        rst_i        = v.rst;
        ifu_valid_i  = v.iv;
        ifu_addr_i   = v.iaddr;
        lsu_valid_i  = v.lv;
        lsu_wen_i    = v.lwen;
        lsu_addr_i   = v.laddr;
        lsu_mask_i   = v.lmask;
        lsu_wdata_i  = v.lwdata;
        mem_ready_i  = v.mrdy;
        mem_rvalid_i = v.mrv;
        mem_rdata_i  = v.mrdata;
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk(idx, "ctrl", {27'd0, ifu_ready_o, ifu_rvalid_o, lsu_ready_o, lsu_rvalid_o, mem_valid_o},
            {27'd0, v.ctrl});
        chk(idx, "ifu_rdata", ifu_rdata_o, v.irdata);
        chk(idx, "lsu_rdata", lsu_rdata_o, v.lrdata);
        if (v.ctrl[0]) begin
            chk(idx, "mem_wen", {31'd0, mem_wen_o}, {31'd0, v.mwen});
            chk(idx, "mem_addr", mem_addr_o, v.maddr);
            chk(idx, "mem_mask", {24'd0, mem_mask_o}, {24'd0, v.mmask});
            chk(idx, "mem_wdata", mem_wdata_o, v.mwdata);
        end
    endtask

    initial begin
        int cyc;
        bit got;
        vec_t idle_v;
        // rst iv iaddr lv lwen laddr lmask lwdata mrdy mrv mrdata | ctrl irdata lrdata mwen maddr mmask mwdata
        // Fetch after reset: accept, request, response
        vq.push_back('{I,O,Z,O,O,Z,8'h00,Z,O,O,Z, 5'b00000,Z,Z,O,Z,8'h00,Z});
        vq.push_back('{O,I,32'h8000_0000,O,O,Z,8'h00,Z,I,O,Z, 5'b00000,Z,Z,O,Z,8'h00,Z});
        vq.push_back('{O,I,32'h8000_0000,O,O,Z,8'h00,Z,I,O,Z, 5'b10000,Z,Z,O,Z,8'h00,Z});
        vq.push_back('{O,O,Z,O,O,Z,8'h00,Z,I,O,Z, 5'b00001,Z,Z,O,32'h8000_0000,8'hFF,Z});
        vq.push_back('{O,O,Z,O,O,Z,8'h00,Z,I,I,32'h0000_0413, 5'b01000,32'h0000_0413,Z,O,Z,8'h00,Z});
        // Stray response while idle
        vq.push_back('{O,O,Z,O,O,Z,8'h00,Z,O,I,32'h0000_1234, 5'b00000,Z,Z,O,Z,8'h00,Z});
        vq.push_back('{O,O,Z,O,O,Z,8'h00,Z,O,O,Z, 5'b00000,Z,Z,O,Z,8'h00,Z});
        // Both requesting: LSU, IFU, LSU
        vq.push_back('{O,I,32'h200,I,O,32'h100,8'h03,32'h5555,O,O,Z, 5'b00100,Z,Z,O,Z,8'h00,Z});
        vq.push_back('{O,I,32'h200,I,O,32'h100,8'h03,32'h5555,I,O,Z, 5'b00001,Z,Z,O,32'h100,8'h03,32'h5555});
        vq.push_back('{O,I,32'h200,I,O,32'h100,8'h03,32'h5555,I,I,32'hAAAA, 5'b00010,Z,32'hAAAA,O,Z,8'h00,Z});
        vq.push_back('{O,I,32'h200,I,O,32'h100,8'h03,32'h5555,O,O,Z, 5'b10000,Z,Z,O,Z,8'h00,Z});
        vq.push_back('{O,I,32'h200,I,O,32'h100,8'h03,32'h5555,I,O,Z, 5'b00001,Z,Z,O,32'h200,8'hFF,Z});
        vq.push_back('{O,I,32'h200,I,O,32'h100,8'h03,32'h5555,I,I,32'hBBBB, 5'b01000,32'hBBBB,Z,O,Z,8'h00,Z});
        vq.push_back('{O,I,32'h200,I,O,32'h100,8'h03,32'h5555,O,O,Z, 5'b00100,Z,Z,O,Z,8'h00,Z});
        vq.push_back('{O,I,32'h200,I,O,32'h100,8'h03,32'h5555,O,O,Z, 5'b00001,Z,Z,O,32'h100,8'h03,32'h5555});
        vq.push_back('{O,I,32'h200,I,O,32'h100,8'h03,32'h5555,I,O,Z, 5'b00001,Z,Z,O,32'h100,8'h03,32'h5555});
        vq.push_back('{O,O,Z,O,O,Z,8'h00,Z,O,I,32'hCCCC, 5'b00010,Z,32'hCCCC,O,Z,8'h00,Z});
        vq.push_back('{O,O,Z,O,O,Z,8'h00,Z,O,O,Z, 5'b00000,Z,Z,O,Z,8'h00,Z});
        // LSU store with 4-cycle stall; IFU pulse and stray response in flight
        vq.push_back('{O,O,Z,I,I,32'h8000_1000,8'h0F,32'hDEAD_BEEF,O,O,Z, 5'b00100,Z,Z,O,Z,8'h00,Z});
        vq.push_back('{O,I,32'h500,I,O,Z,8'h00,Z,O,O,Z, 5'b00001,Z,Z,I,32'h8000_1000,8'h0F,32'hDEAD_BEEF});
        vq.push_back('{O,O,Z,O,O,Z,8'h00,Z,O,I,32'h1111, 5'b00001,Z,Z,I,32'h8000_1000,8'h0F,32'hDEAD_BEEF});
        vq.push_back('{O,O,Z,O,O,Z,8'h00,Z,O,O,Z, 5'b00001,Z,Z,I,32'h8000_1000,8'h0F,32'hDEAD_BEEF});
        vq.push_back('{O,O,Z,O,O,Z,8'h00,Z,O,O,Z, 5'b00001,Z,Z,I,32'h8000_1000,8'h0F,32'hDEAD_BEEF});
        vq.push_back('{O,O,Z,O,O,Z,8'h00,Z,I,O,Z, 5'b00001,Z,Z,I,32'h8000_1000,8'h0F,32'hDEAD_BEEF});
        vq.push_back('{O,O,Z,O,O,Z,8'h00,Z,O,I,32'h1234_5678, 5'b00010,Z,Z,O,Z,8'h00,Z});
        vq.push_back('{O,O,Z,O,O,Z,8'h00,Z,O,O,Z, 5'b00000,Z,Z,O,Z,8'h00,Z});
        vq.push_back('{O,O,Z,O,O,Z,8'h00,Z,O,O,Z, 5'b00000,Z,Z,O,Z,8'h00,Z});
        // Reset while in RESP, then stray responses
        vq.push_back('{O,I,32'h300,O,O,Z,8'h00,Z,O,O,Z, 5'b10000,Z,Z,O,Z,8'h00,Z});
        vq.push_back('{O,O,Z,O,O,Z,8'h00,Z,I,O,Z, 5'b00001,Z,Z,O,32'h300,8'hFF,Z});
        vq.push_back('{I,O,Z,O,O,Z,8'h00,Z,O,I,32'h999, 5'b00000,Z,Z,O,Z,8'h00,Z});
        vq.push_back('{O,O,Z,O,O,Z,8'h00,Z,O,I,32'h999, 5'b00000,Z,Z,O,Z,8'h00,Z});
        vq.push_back('{O,O,Z,O,O,Z,8'h00,Z,O,I,32'h999, 5'b00000,Z,Z,O,Z,8'h00,Z});
        // First contention after reset goes to LSU
        vq.push_back('{O,I,32'h600,I,O,32'h400,8'h03,Z,O,O,Z, 5'b00100,Z,Z,O,Z,8'h00,Z});
        vq.push_back('{O,I,32'h600,I,O,32'h400,8'h03,Z,I,O,Z, 5'b00001,Z,Z,O,32'h400,8'h03,Z});
        vq.push_back('{O,I,32'h600,I,O,32'h400,8'h03,Z,I,I,32'h77, 5'b00010,Z,32'h77,O,Z,8'h00,Z});
        vq.push_back('{O,I,32'h600,I,O,32'h400,8'h03,Z,O,O,Z, 5'b10000,Z,Z,O,Z,8'h00,Z});

        foreach (vq[i]) apply(i, vq[i]);

        // Reset while the IFU request is pending on the memory port
        idle_v = '{O,O,Z,O,O,Z,8'h00,Z,O,O,Z, 5'b00000,Z,Z,O,Z,8'h00,Z};
        @(negedge clk);
        drive(idle_v);
        rst_i = 1'b1;
        #1 chk(100, "rst_in_req_mem_valid", {31'd0, mem_valid_o}, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        ifu_valid_i = 1'b1;
        ifu_addr_i = 32'h700;
        cyc = 0;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            #1;
            if (ifu_ready_o) got = 1'b1;
            else begin
                cyc++;
                @(negedge clk);
            end
        end
        chk(101, "grant_seen", {31'd0, got}, 32'd1);
        chk(102, "grant_latency", cyc, 32'd1);
        @(negedge clk);
        ifu_valid_i = 1'b0;
        mem_ready_i = 1'b1;
        #1;
        chk(103, "req_mem_valid", {31'd0, mem_valid_o}, 32'd1);
        chk(104, "req_mem_addr", mem_addr_o, 32'h700);
        @(negedge clk);
        mem_ready_i = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'h5A5A_0001;
        #1;
        chk(105, "resp_ifu_rvalid", {31'd0, ifu_rvalid_o}, 32'd1);
        chk(106, "resp_ifu_rdata", ifu_rdata_o, 32'h5A5A_0001);
        chk(107, "resp_lsu_rvalid", {31'd0, lsu_rvalid_o}, 32'd0);
        @(negedge clk);
        drive(idle_v);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32: address and data width.
REQ-002 Parameter MASKW, default 8: byte-mask width.
REQ-003 clk_i  in  1  single clock; all logic on posedge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 ifu_valid_i  in  1  IFU read request pending.
REQ-006 ifu_addr_i  in  XLEN  IFU fetch address.
REQ-007 ifu_ready_o  out  1  one-cycle pulse: IFU request accepted.
REQ-008 ifu_rvalid_o  out  1  one-cycle pulse: IFU read data valid.
REQ-009 ifu_rdata_o  out  XLEN  IFU read data.
REQ-010 lsu_valid_i  in  1  LSU request pending.
REQ-011 lsu_wen_i  in  1  1 = store, 0 = load.
REQ-012 lsu_addr_i  in  XLEN  LSU address.
REQ-013 lsu_mask_i  in  MASKW  LSU byte mask.
REQ-014 lsu_wdata_i  in  XLEN  LSU store data.
REQ-015 lsu_ready_o  out  1  one-cycle pulse: LSU request accepted.
REQ-016 lsu_rvalid_o  out  1  one-cycle pulse: LSU load data valid or store complete.
REQ-017 lsu_rdata_o  out  XLEN  LSU load data; 0 for a store.
REQ-018 mem_valid_o  out  1  request to the shared memory port.
REQ-019 mem_wen_o, mem_addr_o, mem_mask_o, mem_wdata_o  out  1/XLEN/MASKW/XLEN  latched request fields.
REQ-020 mem_ready_i  in  1  memory accepts the request.
REQ-021 mem_rvalid_i  in  1  memory response (read data or write done).
REQ-022 mem_rdata_i  in  XLEN  memory read data.

Function
REQ-023 The FSM SHALL have exactly three states, IDLE, REQ and RESP, plus an owner register (IFU/LSU) and a last_owner register.
REQ-024 In IDLE with exactly one valid_i high, the FSM SHALL grant that requester.
REQ-025 In IDLE with both valid_i high, the FSM SHALL grant the requester that is not last_owner (round-robin).
REQ-026 On grant, the FSM SHALL pulse the granted ready_o for that cycle only, latch its fields, set owner and last_owner, and move to REQ on the next cycle.
REQ-027 An IFU grant SHALL latch mem_wen=0, mem_mask=all-ones and mem_wdata=0.
REQ-028 In REQ, mem_valid_o SHALL be 1 with the latched fields held stable until mem_ready_i is 1; the FSM SHALL then move to RESP.
REQ-029 In RESP, the FSM SHALL wait for mem_rvalid_i. In the cycle mem_rvalid_i=1, it SHALL combinationally pulse the owner's rvalid_o and move to IDLE.
REQ-030 During that rvalid_o pulse, the owner's rdata_o SHALL equal mem_rdata_i for a read and 0 for a store.
REQ-031 Each rdata_o SHALL be 0 whenever its rvalid_o is 0.
REQ-032 A new grant SHALL occur no earlier than the cycle after return to IDLE, so the minimum transaction is 3 cycles: accept, request, response.
REQ-033 mem_rvalid_i and mem_ready_i SHALL be ignored outside RESP and REQ respectively.
REQ-034 A valid_i that drops before it is granted SHALL be dropped silently, with no ready_o pulse.
REQ-035 A valid_i change after acceptance SHALL NOT affect the in-flight transaction.
REQ-036 At most one transaction SHALL be outstanding at any time.
REQ-037 The memory port SHALL NOT be driven in IDLE: mem_valid_o=0 there.

Reset
REQ-038 When rst_i=1 at a clock edge, the block SHALL set state=IDLE, owner=IFU and last_owner=IFU, clear all latched fields to 0, and drive all outputs to 0 that cycle and the next.
REQ-039 Reset in REQ or RESP SHALL abandon the transaction with no rvalid_o pulse; a later stray mem_rvalid_i SHALL be ignored.
REQ-040 Because last_owner resets to IFU, the first simultaneous request after reset SHALL be granted to the LSU.

Verification
REQ-041 After reset, ifu_valid=1 and addr=0x80000000; mem_ready=1 immediately; mem_rvalid=1 with rdata=0x00000413 two cycles later -> ifu_ready pulses in cycle 1, mem_valid in cycle 2, and ifu_rvalid with rdata=0x00000413 in cycle 3.
REQ-042 Both valid_i held high across three transactions -> grants in order LSU, IFU, LSU; no overlap.
REQ-043 LSU store: addr=0x80001000, mask=0x0F, wdata=0xDEADBEEF; mem_ready held low 4 cycles -> mem_* fields stable through the stall; lsu_rvalid=1 with lsu_rdata=0.
REQ-044 rst_i=1 while in RESP, followed by mem_rvalid=1 -> no ifu_rvalid or lsu_rvalid pulse; state=IDLE.
REQ-045 mem_rvalid pulsed while IDLE -> no rvalid_o pulse and no state change.
REQ-046 ifu_valid raised for one cycle while the LSU transaction is in flight, then dropped -> no ifu_ready pulse and no IFU transaction.
